// File: rtl/ysyx_23060240_mem_arb_if.sv
// Bundle of IFU, LSU and memory-side signals around the memory arbiter.
// The arbiter takes the slave view; requesters and memory together form the master view.
interface ysyx_23060240_mem_arb_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_we;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_data;
  logic        lsu_rsp_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    input  mem_rsp_valid, mem_rsp_data,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    output mem_rsp_valid, mem_rsp_data,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_23060240_mem_arb.sv
// Shares the single memory port between IFU and LSU: one transaction in flight,
// round-robin on ties, per-transaction timeout reported as an error response.
module ysyx_23060240_mem_arb #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_23060240_mem_arb_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic             r_lastGrant;
  logic             r_owner;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [7:0]       r_wmask;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic w_grantIfu;
  logic w_grantLsu;
  logic w_expire;
  logic w_resp;

  // On a tie the master that did not win last time gets the port.
  always_comb begin
    w_grantIfu = 1'b0;
    w_grantLsu = 1'b0;
    if (r_state == IDLE) begin
      if (bus.ifu_req_valid && bus.lsu_req_valid) begin
        w_grantLsu = (r_lastGrant == OWN_IFU);
        w_grantIfu = !w_grantLsu;
      end else begin
        w_grantIfu = bus.ifu_req_valid;
        w_grantLsu = bus.lsu_req_valid;
      end
    end
  end

  assign w_expire = (TIMEOUT != 0) && (r_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lastGrant <= OWN_IFU;
      r_owner     <= OWN_IFU;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantLsu) begin
            r_owner     <= OWN_LSU;
            r_lastGrant <= OWN_LSU;
            r_we        <= bus.lsu_we;
            r_addr      <= bus.lsu_addr;
            r_wdata     <= bus.lsu_wdata;
            r_wmask     <= bus.lsu_we ? bus.lsu_wmask : 8'h00;
            r_state     <= ISSUE;
          end else if (w_grantIfu) begin
            r_owner     <= OWN_IFU;
            r_lastGrant <= OWN_IFU;
            r_we        <= 1'b0;
            r_addr      <= bus.ifu_addr;
            r_wdata     <= '0;
            r_wmask     <= 8'h00;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A completion arriving on the expiry cycle still counts as success.
          if (bus.mem_rsp_valid) begin
            r_rdata <= r_we ? 32'h0 : bus.mem_rsp_data;
            r_err   <= 1'b0;
            r_state <= RESP;
          end else if (w_expire) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b1;
            r_state <= RESP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_resp = (r_state == RESP);

  assign bus.ifu_req_ready = w_grantIfu;
  assign bus.lsu_req_ready = w_grantLsu;

  assign bus.ifu_rsp_valid = w_resp && (r_owner == OWN_IFU);
  assign bus.ifu_rsp_data  = (r_owner == OWN_IFU) ? r_rdata : 32'h0;
  assign bus.ifu_rsp_err   = bus.ifu_rsp_valid && r_err;
  assign bus.lsu_rsp_valid = w_resp && (r_owner == OWN_LSU);
  assign bus.lsu_rsp_data  = (r_owner == OWN_LSU) ? r_rdata : 32'h0;
  assign bus.lsu_rsp_err   = bus.lsu_rsp_valid && r_err;

  assign bus.mem_req   = (r_state == ISSUE);
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wmask = r_wmask;

endmodule

// File: tb/tb_ysyx_23060240_mem_arb.sv
// Scoreboard bench for the memory arbiter: a small memory model answers each
// mem_req after a per-transaction delay; responses are matched against queued expectations.
module tb_ysyx_23060240_mem_arb;

  localparam int TIMEOUT = 8;

  typedef struct {
    logic        isLsu;
    logic [31:0] data;
    logic        err;
    int          lat;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    int          delay;
    logic [31:0] rdata;
  } mem_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_23060240_mem_arb_if busIf();

  ysyx_23060240_mem_arb #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf.slave)
  );

  rsp_t expRsp[$];
  mem_t expMem[$];
  logic expGrant[$];

  int checkCount = 0;
  int errorCount = 0;
  int cycle = 0;
  int acceptCount = 0;
  int lastAccept = 0;
  int memCnt = 0;
  logic [31:0] memData = 32'h0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, actual, expected, cycle);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Requester-side monitor: grant order on accept, response contents and latency on rsp pulses.
  always @(negedge clk) begin : monitor
    rsp_t e;
    logic g;
    logic [31:0] d;
    logic er;
    if (!rst) begin
      if ((busIf.ifu_req_valid && busIf.ifu_req_ready) || (busIf.lsu_req_valid && busIf.lsu_req_ready)) begin
        checkOutput("readyOneHot", 32'(busIf.ifu_req_ready & busIf.lsu_req_ready), 32'h0);
        if (expGrant.size() > 0) begin
          g = expGrant.pop_front();
          checkOutput("grantOwner", 32'(busIf.lsu_req_valid & busIf.lsu_req_ready), 32'(g));
        end
        acceptCount++;
        lastAccept = cycle;
      end
      if (busIf.ifu_rsp_valid || busIf.lsu_rsp_valid) begin
        checkOutput("rspQueued", 32'(expRsp.size() > 0), 32'h1);
        checkOutput("rspOneHot", 32'(busIf.ifu_rsp_valid & busIf.lsu_rsp_valid), 32'h0);
        if (expRsp.size() > 0) begin
          e  = expRsp.pop_front();
          d  = e.isLsu ? busIf.lsu_rsp_data : busIf.ifu_rsp_data;
          er = e.isLsu ? busIf.lsu_rsp_err : busIf.ifu_rsp_err;
          checkOutput("rspOwner", 32'(busIf.lsu_rsp_valid), 32'(e.isLsu));
          checkOutput("rspData", d, e.data);
          checkOutput("rspErr", 32'(er), 32'(e.err));
          checkOutput("rspLatency", 32'(cycle - lastAccept + 1), 32'(e.lat));
        end
      end
    end
  end

  // Memory model: checks each issue against the queue, then answers after 'delay' cycles (0 = never).
  always @(negedge clk) begin : memModel
    mem_t m;
    busIf.mem_rsp_valid = 1'b0;
    busIf.mem_rsp_data  = 32'hBAD0BAD0;
    if (rst) begin
      memCnt = 0;
    end else begin
      if (memCnt > 0) begin
        memCnt--;
        if (memCnt == 0) begin
          busIf.mem_rsp_valid = 1'b1;
          busIf.mem_rsp_data  = memData;
        end
      end
      if (busIf.mem_req) begin
        checkOutput("memQueued", 32'(expMem.size() > 0), 32'h1);
        if (expMem.size() > 0) begin
          m = expMem.pop_front();
          checkOutput("memWe", 32'(busIf.mem_we), 32'(m.we));
          checkOutput("memAddr", busIf.mem_addr, m.addr);
          checkOutput("memWmask", 32'(busIf.mem_wmask), 32'(m.wmask));
          if (m.we) checkOutput("memWdata", busIf.mem_wdata, m.wdata);
          memCnt  = m.delay;
          memData = m.rdata;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExpect(input logic isLsu, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [7:0] wmask,
                            input int delay, input logic [31:0] rdata);
    mem_t m;
    rsp_t r;
    logic ok;
    ok      = (delay >= 1) && (delay <= TIMEOUT);
    m.we    = isLsu & we;
    m.addr  = addr;
    m.wdata = wdata;
    m.wmask = (isLsu & we) ? wmask : 8'h00;
    m.delay = delay;
    m.rdata = rdata;
    expMem.push_back(m);
    r.isLsu = isLsu;
    r.data  = (m.we || !ok) ? 32'h0 : rdata;
    r.err   = !ok;
    // Inclusive count: accept, issue, the WAIT cycles, response.
    r.lat   = ok ? delay + 3 : TIMEOUT + 3;
    expRsp.push_back(r);
  endtask

  task automatic waitAccepts(input int target, input int budget);
    int n;
    n = 0;
    while (acceptCount < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("acceptCount", 32'(acceptCount), 32'(target));
  endtask

  task automatic waitRspDrain(input int budget);
    int n;
    n = 0;
    while (expRsp.size() > 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("rspDrained", 32'(expRsp.size()), 32'h0);
  endtask

  task automatic applyStimulus(input logic isLsu, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [7:0] wmask,
                               input int delay, input logic [31:0] rdata);
    int target;
    pushExpect(isLsu, we, addr, wdata, wmask, delay, rdata);
    target = acceptCount + 1;
    @(posedge clk); #1;
    if (isLsu) begin
      busIf.lsu_req_valid = 1'b1;
      busIf.lsu_we        = we;
      busIf.lsu_addr      = addr;
      busIf.lsu_wdata     = wdata;
      busIf.lsu_wmask     = wmask;
    end else begin
      busIf.ifu_req_valid = 1'b1;
      busIf.ifu_addr      = addr;
    end
    waitAccepts(target, 20);
    @(posedge clk); #1;
    busIf.ifu_req_valid = 1'b0;
    busIf.lsu_req_valid = 1'b0;
    busIf.lsu_addr      = 32'hFFFF_FFFF;
    busIf.lsu_wdata     = 32'hFFFF_FFFF;
    busIf.ifu_addr      = 32'hFFFF_FFFF;
    waitRspDrain(40);
    repeat (3) @(posedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_memReq"},   32'(busIf.mem_req), 32'h0);
    checkOutput({tag, "_memWe"},    32'(busIf.mem_we), 32'h0);
    checkOutput({tag, "_memAddr"},  busIf.mem_addr, 32'h0);
    checkOutput({tag, "_memWdata"}, busIf.mem_wdata, 32'h0);
    checkOutput({tag, "_memWmask"}, 32'(busIf.mem_wmask), 32'h0);
    checkOutput({tag, "_ifuRsp"},   32'(busIf.ifu_rsp_valid), 32'h0);
    checkOutput({tag, "_lsuRsp"},   32'(busIf.lsu_rsp_valid), 32'h0);
    checkOutput({tag, "_ifuErr"},   32'(busIf.ifu_rsp_err), 32'h0);
    checkOutput({tag, "_ifuData"},  busIf.ifu_rsp_data, 32'h0);
    checkOutput({tag, "_lsuData"},  busIf.lsu_rsp_data, 32'h0);
    checkOutput({tag, "_ifuRdy"},   32'(busIf.ifu_req_ready), 32'h0);
    checkOutput({tag, "_lsuRdy"},   32'(busIf.lsu_req_ready), 32'h0);
  endtask

  initial begin
    int target;
    busIf.ifu_req_valid = 1'b0;
    busIf.ifu_addr      = 32'h0;
    busIf.lsu_req_valid = 1'b0;
    busIf.lsu_we        = 1'b0;
    busIf.lsu_addr      = 32'h0;
    busIf.lsu_wdata     = 32'h0;
    busIf.lsu_wmask     = 8'h00;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Tie right after reset: LSU first, then strict alternation while both are held.
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        pushExpect(1'b1, 1'b0, 32'h8000_0040, 32'h5555_AAAA, 8'hFF, 1, 32'hA000_0000 + 32'(i));
        expMem[$].rdata = 32'hA000_0000 + 32'(i);
        expGrant.push_back(1'b1);
      end else begin
        pushExpect(1'b0, 1'b0, 32'h8000_0080, 32'h0, 8'h00, 1, 32'hB000_0000 + 32'(i));
        expGrant.push_back(1'b0);
      end
    end
    target = acceptCount + 4;
    busIf.ifu_req_valid = 1'b1;
    busIf.ifu_addr      = 32'h8000_0080;
    busIf.lsu_req_valid = 1'b1;
    busIf.lsu_we        = 1'b0;
    busIf.lsu_addr      = 32'h8000_0040;
    busIf.lsu_wdata     = 32'h5555_AAAA;
    busIf.lsu_wmask     = 8'hFF;
    waitAccepts(target, 100);
    @(posedge clk); #1;
    busIf.ifu_req_valid = 1'b0;
    busIf.lsu_req_valid = 1'b0;
    waitRspDrain(40);
    checkOutput("grantQueueEmpty", 32'(expGrant.size()), 32'h0);
    repeat (2) @(posedge clk);

    applyStimulus(1'b0, 1'b0, 32'h8000_0000, 32'h0, 8'h00, 1, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b1, 32'h8000_0004, 32'h1234_5678, 8'h0F, 1, 32'h7777_7777);
    applyStimulus(1'b1, 1'b0, 32'h8000_0010, 32'hFFFF_FFFF, 8'hFF, 3, 32'h1122_3344);
    applyStimulus(1'b0, 1'b0, 32'h8000_0008, 32'h0, 8'h00, TIMEOUT + 2, 32'hCAFE_F00D);
    repeat (4) @(posedge clk);
    applyStimulus(1'b1, 1'b0, 32'h8000_000C, 32'h0, 8'h00, TIMEOUT, 32'h0BAD_CAFE);
    applyStimulus(1'b1, 1'b1, 32'h8000_0020, 32'hAABB_CCDD, 8'hF0, 0, 32'h0);

    // Reset in the middle of WAIT: the transaction must vanish without a response.
    begin
      mem_t m;
      m.we = 1'b0; m.addr = 32'h8000_0100; m.wdata = 32'h0;
      m.wmask = 8'h00; m.delay = 0; m.rdata = 32'h0;
      expMem.push_back(m);
    end
    target = acceptCount + 1;
    @(posedge clk); #1;
    busIf.ifu_req_valid = 1'b1;
    busIf.ifu_addr      = 32'h8000_0100;
    waitAccepts(target, 20);
    @(posedge clk); #1;
    busIf.ifu_req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("midReset");
    repeat (TIMEOUT + 4) @(posedge clk);
    checkOutput("noRspAfterReset", 32'(expRsp.size()), 32'h0);

    applyStimulus(1'b0, 1'b0, 32'h8000_0200, 32'h0, 8'h00, 2, 32'h0F0F_1234);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
